evt_trigger_sequencer: RTL
==========================

Name: evt_trigger_sequencer

Overview:
- Event producer and checker: fires one-cycle trigger pulses on NUM_EVT event lines in index order.
- Collects each consumer's acknowledgement into a triggered vector and reports pass or fail.
- Serves as the initiating end of the event/handshake path in the timing regression benches; it drives the consumer blocks that wait on events and set triggered bits.
- Single clock domain.

Parameters:
- NUM_EVT, 2, number of event lines and ack lines (1..16).
- GAP, 2, idle cycles before each trigger pulse (1..255).
- ACK_TIMEOUT, 4, max cycles after a pulse for its ack to arrive (1..255).

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin a sequence; sampled only in IDLE.
- ack  input  NUM_EVT  per-event acknowledge from consumers; level or pulse.
- evt  output  NUM_EVT  one-hot trigger pulse, one cycle wide.
- triggered  output  NUM_EVT  sticky record of acks received this run.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the sequence ends.
- pass  output  1  valid when done=1; holds until next start.
- fail_idx  output  $clog2(NUM_EVT)+1  index of the offending event; all-ones if no failure.
- cyc  output  16  cycles elapsed since start accepted; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, evt=0, triggered=0, busy=0, done=0, pass=0, fail_idx=all-ones, cyc=0, idx=0, gap/timeout counters=0.
- rst has priority over every other input. Reset mid-sequence aborts with no done pulse.
- States: IDLE, GAP, FIRE, WAIT_ACK, FINISH.
- IDLE:
  - If start=1: clear triggered, set pass=0, set fail_idx=all-ones, set idx=0, set cyc=0, load gap counter=GAP.
  - Go to GAP; busy=1 from the next cycle.
- GAP:
  - Decrement the gap counter each cycle; at 1, go to FIRE.
  - Pre-trigger check: any ack bit j with j>=idx asserted during GAP is a spurious ack. Record fail_idx=j (lowest such j) and go to FINISH.
- FIRE:
  - evt[idx]=1 for exactly this cycle; all other evt bits 0.
  - Load timeout counter=ACK_TIMEOUT; go to WAIT_ACK.
  - An ack[idx] sampled in the FIRE cycle itself counts as received (0-cycle consumer).
- WAIT_ACK:
  - ack[idx]=1: set triggered[idx]=1.
    - If idx==NUM_EVT-1, set pass=1 and go to FINISH.
    - Otherwise increment idx, reload the gap counter, and go to GAP.
  - ack[j]=1 for j>idx: spurious; fail_idx=j, go to FINISH.
  - Otherwise decrement the timeout counter; at 0 with no ack, fail_idx=idx, go to FINISH.
  - Simultaneous ack[idx] and a spurious ack[j] in the same cycle: the spurious ack wins, and triggered[idx] is still set.
- ack bits j<idx are already-serviced events and are ignored after their triggered bit is set.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. pass, fail_idx and triggered hold until the next accepted start.
- start while busy is ignored. start in the same cycle as done is ignored; it is accepted one cycle later in IDLE.
- cyc:
  - Increments every cycle while busy, saturating at 16'hFFFF.
  - Holds after done; cleared only when a start is accepted or on reset.
- Nominal latency from start to done with all acks arriving in the FIRE cycle: NUM_EVT*(GAP+2)+1 cycles.
- All outputs are registered; no combinational path from ack to evt.

Test Plan:
- Reset then start, consumers ack in the FIRE cycle, defaults -> evt[0] pulses at cycle 3 and evt[1] at cycle 7; done at cycle 9 with pass=1, triggered=2'b11, fail_idx=2'b11, cyc=9.
- Consumer ack[1] delayed 4 cycles after evt[1] (ACK_TIMEOUT=4) -> accepted, pass=1; delay of 5 -> done with pass=0, fail_idx=1, triggered=2'b01.
- ack[1] asserted during the GAP before evt[0] -> done with pass=0, fail_idx=1, triggered=2'b00, and evt[0] never pulses.
- rst asserted for 1 cycle while in WAIT_ACK for idx=1 -> next cycle all outputs at reset values, no done pulse; a new start then runs normally to pass=1.
- start held high continuously through a run -> exactly one sequence per IDLE entry; second run begins the cycle after done, and cyc restarts at 0.
- NUM_EVT=4, GAP=1, ack[2] and ack[3] asserted together in evt[2]'s WAIT_ACK -> fail_idx=3, triggered=4'b0111, pass=0.

Source files
------------

// File: rtl/evt_trigger_sequencer.sv
// Event trigger sequencer: pulses evt[i] in index order after GAP idle cycles,
// collects each consumer's ack into a sticky vector and reports pass/fail.
module evt_trigger_sequencer #(
  parameter int NUM_EVT     = 2,
  parameter int GAP         = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_EVT-1:0]         ack,
  output logic [NUM_EVT-1:0]         evt,
  output logic [NUM_EVT-1:0]         triggered,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(NUM_EVT):0]   fail_idx,
  output logic [15:0]                cyc
);

  localparam int FW = $clog2(NUM_EVT) + 1;
  localparam logic [FW-1:0] NO_FAIL  = {FW{1'b1}};
  localparam logic [FW-1:0] LAST_IDX = FW'(NUM_EVT - 1);
  localparam logic [7:0]    GAP_LD   = 8'(GAP);
  localparam logic [7:0]    TO_LD    = 8'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GAP    = 3'd1,
    S_FIRE   = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [FW-1:0]        idx, idx_nx;
  logic [7:0]           gap_cnt, gap_nx;
  logic [7:0]           to_cnt, to_nx;
  logic                 pend, pend_nx;
  logic [NUM_EVT-1:0]   evt_nx, trig_nx;
  logic                 busy_nx, done_nx, pass_nx;
  logic [FW-1:0]        fail_nx;
  logic [15:0]          cyc_nx;
  logic                 ack_cur, hit;
  logic [NUM_EVT-1:0]   spur_ge_vec, spur_gt_vec;

  function automatic logic [NUM_EVT-1:0] onehot(input logic [FW-1:0] i);
    logic [NUM_EVT-1:0] v;
    v = {NUM_EVT{1'b0}};
    for (int j = 0; j < NUM_EVT; j++) begin
      v[j] = (FW'(j) == i);
    end
    return v;
  endfunction

  // Lines at or above (incl=1) / strictly above (incl=0) the current index.
  function automatic logic [NUM_EVT-1:0] above_mask(input logic [FW-1:0] i, input logic incl);
    logic [NUM_EVT-1:0] m;
    m = {NUM_EVT{1'b0}};
    for (int j = 0; j < NUM_EVT; j++) begin
      m[j] = incl ? (FW'(j) >= i) : (FW'(j) > i);
    end
    return m;
  endfunction

  function automatic logic [FW-1:0] lowest_set(input logic [NUM_EVT-1:0] v);
    logic [FW-1:0] r;
    r = {FW{1'b0}};
    for (int j = NUM_EVT - 1; j >= 0; j--) begin
      if (v[j]) r = FW'(j);
      else      r = r;
    end
    return r;
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    gap_nx      = gap_cnt;
    to_nx       = to_cnt;
    pend_nx     = pend;
    trig_nx     = triggered;
    pass_nx     = pass;
    fail_nx     = fail_idx;
    ack_cur     = |(ack & onehot(idx));
    hit         = ack_cur | pend;
    spur_ge_vec = ack & above_mask(idx, 1'b1);
    spur_gt_vec = ack & above_mask(idx, 1'b0);

    if (state != S_IDLE && cyc != 16'hFFFF) cyc_nx = cyc + 16'd1;
    else                                   cyc_nx = cyc;

    case (state)
      S_IDLE: begin
        if (start) begin
          trig_nx  = {NUM_EVT{1'b0}};
          pass_nx  = 1'b0;
          fail_nx  = NO_FAIL;
          idx_nx   = {FW{1'b0}};
          cyc_nx   = 16'd0;
          gap_nx   = GAP_LD;
          state_nx = S_GAP;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_GAP: begin
        gap_nx = gap_cnt - 8'd1;
        if (|spur_ge_vec) begin
          fail_nx  = lowest_set(spur_ge_vec);
          state_nx = S_FINISH;
        end else if (gap_cnt <= 8'd1) begin
          state_nx = S_FIRE;
        end else begin
          state_nx = S_GAP;
        end
      end
      S_FIRE: begin
        // A same-cycle consumer answers while evt is high; remember it.
        pend_nx  = ack_cur;
        to_nx    = TO_LD;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        pend_nx = 1'b0;
        if (hit) trig_nx = triggered | onehot(idx);
        else     trig_nx = triggered;
        if (|spur_gt_vec) begin
          fail_nx  = lowest_set(spur_gt_vec);
          state_nx = S_FINISH;
        end else if (hit) begin
          if (idx == LAST_IDX) begin
            pass_nx  = 1'b1;
            state_nx = S_FINISH;
          end else begin
            idx_nx   = idx + {{(FW-1){1'b0}}, 1'b1};
            gap_nx   = GAP_LD;
            state_nx = S_GAP;
          end
        end else if (to_cnt <= 8'd1) begin
          to_nx    = 8'd0;
          fail_nx  = idx;
          state_nx = S_FINISH;
        end else begin
          to_nx    = to_cnt - 8'd1;
          state_nx = S_WAIT;
        end
      end
      S_FINISH: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    evt_nx  = (state_nx == S_FIRE) ? onehot(idx_nx) : {NUM_EVT{1'b0}};
    busy_nx = (state_nx == S_GAP) || (state_nx == S_FIRE) || (state_nx == S_WAIT);
    done_nx = (state_nx == S_FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= {FW{1'b0}};
      gap_cnt   <= 8'd0;
      to_cnt    <= 8'd0;
      pend      <= 1'b0;
      evt       <= {NUM_EVT{1'b0}};
      triggered <= {NUM_EVT{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_idx  <= NO_FAIL;
      cyc       <= 16'd0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      gap_cnt   <= gap_nx;
      to_cnt    <= to_nx;
      pend      <= pend_nx;
      evt       <= evt_nx;
      triggered <= trig_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      fail_idx  <= fail_nx;
      cyc       <= cyc_nx;
    end
  end

endmodule
